fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit for the five-stage RV32I core, sitting directly upstream of the IF/ID pipeline register. It replaces direct combinational reads of the instruction scratchpad with a pipelined request/grant/response memory port. It prefetches sequential words into a small in-order buffer and hands `{pc, instr}` pairs to decode over a valid/ready handshake. It also flushes and redirects on a taken branch or jump from EX.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: prefetch buffer entries, and also the maximum number of outstanding requests plus buffered entries. Must be a power of two and ≥ 2.
- `clk_i`  in  1  the single clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `imem_req_o`  out  1  request valid.
- `imem_addr_o`  out  32  word-aligned request address (bits [1:0] always 0).
- `imem_gnt_i`  in  1  request accepted this cycle (when `imem_req_o` is high).
- `imem_rvalid_i`  in  1  read data valid. Responses arrive in request order, ≥1 cycle after grant.
- `imem_rdata_i`  in  32  instruction word.
- `redirect_i`  in  1  taken branch/jump from EX; single-cycle pulse.
- `redirect_pc_i`  in  32  redirect target.
- `if_valid_o`  out  1  buffer head valid.
- `if_pc_o`  out  32  PC of head entry.
- `if_instr_o`  out  32  instruction of head entry.
- `if_ready_i`  in  1  decode accepts head.
- `misalign_o`  out  1  fetch target misaligned (present only with `FETCH_MISALIGN_TRAP_EN`).

## Operation
- State machine: BOOT, RUN, FLUSH (plus HALT, only with the macro).
  - BOOT: the single cycle after reset release, with no requests issued. Transitions to RUN.
  - RUN: issues requests whenever `outstanding + count < DEPTH`, using registered values only (a pop does not free a credit until the next cycle).
  - RUN, on `redirect_i`: `fetch_pc <= redirect_pc_i`, buffer emptied. If `outstanding_next > 0`, go to FLUSH with `discard <= outstanding_next`; otherwise stay in RUN.
  - FLUSH: no requests issued. Each `imem_rvalid_i` decrements `discard` and its data is dropped. When `discard` reaches 0, return to RUN.
  - FLUSH, on another `redirect_i`: update `fetch_pc`; `discard` tracks all still-outstanding responses.
- Request handshake:
  - `imem_addr_o = fetch_pc`.
  - On `req & gnt`: `fetch_pc += 4` (wraps modulo 2^32) and `outstanding++`.
  - While `req & !gnt`, address and request are held stable. The only exception is a redirect cycle, in which `imem_req_o` is forced to 0 (withdrawal is permitted).
- Response handling in RUN:
  - `rvalid` writes `{resp_pc, rdata}` at the buffer tail.
  - `resp_pc` is a separate counter that advances by 4 per accepted response and is reloaded on redirect.
- Output side:
  - `if_valid_o = (count != 0)`.
  - Pop on `if_valid_o & if_ready_i`.
  - When the buffer is empty, `if_pc_o`/`if_instr_o` hold their last value.
- Simultaneous events:
  - Redirect with pop: redirect wins; the buffer is cleared regardless.
  - Redirect with rvalid: that response is discarded.
  - Push and pop in the same cycle: `count` is unchanged.
- A buffer overflow cannot occur because of the credit rule. The bench checks this with an assertion.

## Timing
- Reset values:
  - `imem_req_o = 0`, `imem_addr_o = RESET_PC`.
  - `if_valid_o = 0`, `if_pc_o = 0`, `if_instr_o = 0`.
  - `misalign_o = 0`.
  - Internal: `count`, `outstanding` and `discard` all 0; state BOOT.
- First request is asserted in cycle 1 after reset release.
- Grant at cycle N, rvalid at N+1 → `if_valid_o` high at N+2. Minimum latency is 2 cycles from grant to decode.
- With `DEPTH = 4` and a 1-cycle memory, sustained throughput is 1 instruction per cycle.
- Redirect at cycle R → first request to the target at R+1 if nothing is outstanding; otherwise one cycle after the last discarded response.
- Reset asserted mid-operation clears everything immediately. Responses still in flight from before reset are the memory's responsibility to squash.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - `redirect_pc_i[1:0] != 0` → flush, enter HALT, and assert sticky `misalign_o`.
  - In HALT, no requests are issued and `if_valid_o = 0`.
  - Exit HALT to RUN on the next aligned redirect, which also clears `misalign_o`.
- Undefined:
  - `redirect_pc_i[1:0]` is ignored (forced to 0).
  - No `misalign_o` port and no HALT state.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_e` enum (BOOT, RUN, FLUSH, HALT).
  - `fetch_entry_t` struct `{pc[31:0], instr[31:0]}`.
  - Constant `INSTR_BYTES = 4`.
- Sub-module `fetch_fifo`: parameterised-depth synchronous FIFO of `fetch_entry_t`, with a flush input, `count` output, and simultaneous push/pop support.

## Test plan
- Reset release with a 1-cycle-latency memory that always grants:
  - PCs 0, 4, 8, 12 are presented in order.
  - `if_valid_o` first goes high in cycle 3.
  - One instruction per cycle after that.
- `if_ready_i` held at 0 for 10 cycles:
  - At most 4 requests are issued, then `imem_req_o` stays low.
  - No data is lost after ready returns.
- `imem_gnt_i` low for 3 cycles:
  - `imem_addr_o` stays stable at 0x10.
  - No duplicate fetches occur.
- Redirect to 0x200 with 2 outstanding requests:
  - Both responses are dropped.
  - The next `if_pc_o` is 0x200.
  - The buffer is empty the cycle after the redirect.
- Redirect in the same cycle as a pop and an rvalid: the popped entry is not re-presented and the rvalid data never appears.
- With the macro defined, redirect to 0x102:
  - `misalign_o` goes to 1 and no requests are issued.
  - A redirect to 0x100 then resumes fetch and clears `misalign_o`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer of {pc, instr} entries with flush and simultaneous push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [ENTRY_W-1:0]       wdata_i,
    input  logic                     pop_i,
    output logic [ENTRY_W-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    fetch_entry_t  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: request/grant/response port feeding an in-order prefetch buffer.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises sticky misalign_o.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    fetch_entry_t  last_q, last_d;
    fetch_entry_t  head, push_entry;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic [31:0]   redir_pc;
    logic          redir_bad;
    logic          credit_ok, gnt_fire, rsp_fire, push, pop;

    assign redir_pc = redirect_pc_i & PC_MASK;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_bad = |redirect_pc_i[1:0];
`else
    assign redir_bad = 1'b0;
`endif

    // Credits come from registered state only, so a pop frees its slot one cycle later.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, count};
    assign credit_ok   = credit_used < DEPTH_C;

    assign gnt_fire      = imem_req_o & imem_gnt_i;
    assign rsp_fire      = imem_rvalid_i & (outstanding_q != '0);
    assign outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
    assign push          = rsp_fire & (state_q == RUN) & ~redirect_i;
    assign pop           = if_valid_o & if_ready_i & ~redirect_i;
    assign push_entry    = '{pc: resp_pc_q, instr: imem_rdata_i};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            if (redir_bad)                   state_d = HALT;
            else if (outstanding_d != '0)    state_d = FLUSH;
            else                             state_d = RUN;
        end else begin
            unique case (state_q)
                BOOT:    state_d = RUN;
                FLUSH:   if (discard_d == '0) state_d = RUN;
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_req_o = 1'b0;
        if_valid_o = (count != '0);
        if (state_q == RUN && credit_ok && !redirect_i) imem_req_o = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (state_q == HALT) if_valid_o = 1'b0;
`endif
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        last_d     = (count != '0) ? head : last_q;
        if (redirect_i) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            discard_d  = outstanding_d;
        end else begin
            if (gnt_fire) fetch_pc_d = fetch_pc_q + INSTR_BYTES;
            if (push)     resp_pc_d  = resp_pc_q + INSTR_BYTES;
            if (rsp_fire && state_q == FLUSH && discard_q != '0)
                discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC & PC_MASK;
            resp_pc_q     <= RESET_PC & PC_MASK;
            outstanding_q <= '0;
            discard_q     <= '0;
            last_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            last_q        <= last_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign misalign_d = redirect_i ? redir_bad : misalign_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end

    assign misalign_o = misalign_q;
`endif

    assign imem_addr_o = fetch_pc_q;
    // With the buffer empty the last presented entry is held rather than stale storage.
    assign if_pc_o     = (count != '0) ? head.pc    : last_q.pc;
    assign if_instr_o  = (count != '0) ? head.instr : last_q.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed phases plus randomized memory timing and redirects.
// Build with FETCH_MISALIGN_TRAP_EN defined to also exercise the misalign trap.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o, if_ready_i;
    logic [31:0] if_pc_o, if_instr_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_o    (misalign_o),
`endif
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_ready_i    (if_ready_i)
    );

    always #5 clk = ~clk;

    // Reference model: memory requests in flight (tagged with the redirect epoch that issued them)
    // and the PCs that decode should see, in order.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] bufq[$];
    logic [31:0] popped[$];
    logic [31:0] fetch_ptr, last_pc, last_instr;
    int          epoch, cyc, checks, errors, lat_min, lat_max, first_valid_cyc, ngrant;
    bit          boot, halt, obs_req, obs_valid;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        bufq.delete();
        popped.delete();
        fetch_ptr       = RESET_PC & 32'hFFFF_FFFC;
        last_pc         = '0;
        last_instr      = '0;
        halt            = 1'b0;
        boot            = 1'b1;
        epoch++;
        cyc             = 0;
        first_valid_cyc = -1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req",   imem_req_o,  0);
        check("rst_addr",  imem_addr_o, RESET_PC);
        check("rst_valid", if_valid_o,  0);
        check("rst_pc",    if_pc_o,     0);
        check("rst_instr", if_instr_o,  0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misalign", misalign_o, 0);
`endif
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later, advance the model.
    task automatic tick(input bit redir, input logic [31:0] rpc, input bit rdy, input bit gnt);
        bit    rv, old_pend, exp_req;
        mreq_t r;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if_ready_i    = rdy;
        imem_gnt_i    = gnt;
        rv            = (memq.size() != 0) && (memq[0].due <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? word(memq[0].addr) : $urandom();
        #1;
        obs_req   = imem_req_o;
        obs_valid = if_valid_o;
        old_pend  = 1'b0;
        foreach (memq[i]) if (memq[i].epoch != epoch) old_pend = 1'b1;
        exp_req = !boot && !halt && !redir && !old_pend && (memq.size() + bufq.size() < DEPTH);
        check("req", obs_req, exp_req);
        check("addr", imem_addr_o, fetch_ptr);
        check("no_overflow", (memq.size() + bufq.size()) <= DEPTH, 1);
        check("valid", obs_valid, bufq.size() != 0);
        if (bufq.size() != 0) begin
            check("head_pc", if_pc_o, bufq[0]);
            check("head_instr", if_instr_o, word(bufq[0]));
            last_pc    = bufq[0];
            last_instr = word(bufq[0]);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
            check("hold_pc", if_pc_o, last_pc);
            check("hold_instr", if_instr_o, last_instr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign", misalign_o, halt);
`endif
        if (bufq.size() != 0 && rdy && !redir) popped.push_back(bufq.pop_front());
        if (rv) begin
            r = memq.pop_front();
            if (!redir && !halt && r.epoch == epoch) bufq.push_back(r.addr);
        end
        if (obs_req && gnt) begin
            r.addr  = fetch_ptr;
            r.epoch = epoch;
            r.due   = cyc + $urandom_range(lat_max, lat_min);
            memq.push_back(r);
            fetch_ptr += 32'd4;
            ngrant++;
        end
        if (redir) begin
            epoch++;
            bufq.delete();
            fetch_ptr = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt = (rpc[1:0] != 2'b00);
`endif
        end
        boot = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int          n, g0;
        logic [31:0] tgt;
        checks = 0; errors = 0; epoch = 0; ngrant = 0;
        lat_min = 1; lat_max = 1;
        rst = 1'b1;
        redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        model_reset();
        rst = 1'b0;

        // Back-to-back fetch with a 1-cycle memory that always grants.
        repeat (16) tick(0, 0, 1, 1);
        check("first_valid_cycle", first_valid_cyc, 3);
        check("throughput_pops", popped.size(), 13);
        for (int i = 0; i < 4; i++)
            check("boot_pc_seq", (i < popped.size()) ? popped[i] : 32'hFFFF_FFFF, 32'(i * 4));

        // Decode stalls for 10 cycles; buffer fills, requests stop, nothing is lost.
        popped.delete();
        g0 = ngrant;
        repeat (10) tick(0, 0, 0, 1);
        check("stall_grants_le_depth", (ngrant - g0) <= DEPTH, 1);
        check("stall_req_low", obs_req, 0);
        check("stall_full_valid", obs_valid, 1);
        repeat (12) tick(0, 0, 1, 1);
        check("resume_pc", (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF, 32'h34);

        // Grant withheld for 3 cycles at address 0x10.
        popped.delete();
        tick(1, 32'h10, 1, 0);
        n = 0;
        while (!obs_req && n < 20) begin tick(0, 0, 1, 0); n++; end
        check("gnt_wait_bound", obs_req, 1);
        repeat (2) begin
            tick(0, 0, 1, 0);
            check("gnt_hold_req", obs_req, 1);
        end
        tick(0, 0, 1, 1);
        repeat (10) tick(0, 0, 1, 1);
        check("gnt_first_pc", (popped.size() > 0) ? popped[0] : 32'hFFFF_FFFF, 32'h10);
        check("gnt_no_dup", (popped.size() > 1) ? popped[1] : 32'hFFFF_FFFF, 32'h14);

        // Redirect to 0x200 with exactly two requests outstanding.
        lat_min = 3; lat_max = 3;
        n = 0;
        while (memq.size() != 0 && n < 20) begin tick(0, 0, 1, 0); n++; end
        check("drain_bound", memq.size(), 0);
        repeat (2) tick(0, 0, 1, 1);
        check("two_outstanding", memq.size(), 2);
        popped.delete();
        tick(1, 32'h200, 1, 1);
        tick(0, 0, 1, 1);
        check("flush_empty", obs_valid, 0);
        repeat (15) tick(0, 0, 1, 1);
        check("redirect_first_pc", (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF, 32'h200);

        // Redirect coinciding with a pop and an rvalid.
        lat_min = 1; lat_max = 1;
        repeat (8) tick(0, 0, 1, 1);
        popped.delete();
        tick(1, 32'h300, 1, 1);
        check("collide_valid", obs_valid, 1);
        repeat (10) tick(0, 0, 1, 1);
        check("collide_first_pc", (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF, 32'h300);

        // Randomized memory timing, decode stalls and redirects, including PC wrap.
        lat_min = 1; lat_max = 3;
        tick(1, 32'hFFFF_FFF8, 1, 1);
        for (int i = 0; i < 400; i++) begin
            tgt = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            tick($urandom_range(0, 24) == 0, tgt, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps; an aligned one resumes.
        lat_min = 1; lat_max = 1;
        tick(1, 32'h102, 1, 1);
        repeat (5) begin
            tick(0, 0, 1, 1);
            check("halt_req", obs_req, 0);
            check("halt_misalign", misalign_o, 1);
        end
        popped.delete();
        tick(1, 32'h100, 1, 1);
        check("resume_misalign_clr", misalign_o, 0);
        repeat (15) tick(0, 0, 1, 1);
        check("resume_first_pc", (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF, 32'h100);
`endif

        // Reset asserted mid-operation.
        lat_min = 1; lat_max = 2;
        repeat (6) tick(0, 0, 1, 1);
        rst = 1'b1;
        redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        lat_min = 1; lat_max = 1;
        repeat (10) tick(0, 0, 1, 1);
        check("rerun_first_valid", first_valid_cyc, 3);
        check("rerun_first_pc", (popped.size() != 0) ? popped[0] : 32'hFFFF_FFFF, RESET_PC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
